// File: rtl/gpr_ctx_mover.sv
// gpr_ctx_mover: moves the general purpose register file to or from a
// context frame in data memory for interrupt entry and exit.
// SAVE streams one GPR per cycle into memory. RESTORE issues one memory read
// per cycle and writes each returned byte into the GPR one cycle later.
// Strobes and addresses come from flops. The two data outputs pass through
// combinationally from the read ports, gated so they read zero while idle.
module gpr_ctx_mover #(
   parameter int NREGS  = 9,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              save_req,
   input  logic              restore_req,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              busy,
   output logic              done,
   output logic [3:0]        gpr_r_addr,
   input  logic [DATA_W-1:0] gpr_r_data,
   output logic              gpr_w_enable,
   output logic [3:0]        gpr_w_addr,
   output logic [DATA_W-1:0] gpr_w_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SAVE    = 2'd1,
      RESTORE = 2'd2,
      DONE    = 2'd3
   } state_t;

   // Index of the last register moved, and the extra write-only restore cycle
   localparam logic [3:0] LAST_IDX  = 4'(NREGS - 1);
   localparam logic [3:0] FINAL_IDX = 4'(NREGS);

   state_t            state_r;
   logic [3:0]        idx_r;
   logic [ADDR_W-1:0] base_r;
   logic              busy_r;
   logic              done_r;
   logic [3:0]        gpr_r_addr_r;
   logic              gpr_w_enable_r;
   logic [3:0]        gpr_w_addr_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic              mem_we_r;
   logic              mem_re_r;

   logic [3:0]        idx_inc_s;
   logic [ADDR_W-1:0] next_addr_s;

   // Next index and the frame address it maps to (wraps modulo 2^ADDR_W)
   always_comb begin
      idx_inc_s   = idx_r + 4'd1;
      next_addr_s = base_r + ADDR_W'(idx_inc_s);
   end

   // Sequencer: advances the state and registers every strobe/address for the next cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= IDLE;
         idx_r          <= 4'd0;
         base_r         <= {ADDR_W{1'b0}};
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
         gpr_r_addr_r   <= 4'd0;
         gpr_w_enable_r <= 1'b0;
         gpr_w_addr_r   <= 4'd0;
         mem_addr_r     <= {ADDR_W{1'b0}};
         mem_we_r       <= 1'b0;
         mem_re_r       <= 1'b0;
      end else begin
         // Strobes are single-cycle unless re-armed below
         done_r         <= 1'b0;
         gpr_w_enable_r <= 1'b0;
         mem_we_r       <= 1'b0;
         mem_re_r       <= 1'b0;
         gpr_r_addr_r   <= 4'd0;
         gpr_w_addr_r   <= 4'd0;
         mem_addr_r     <= {ADDR_W{1'b0}};
         case (state_r)
            IDLE: begin
               if (save_req) begin
                  // SAVE takes priority over a simultaneous RESTORE request
                  state_r    <= SAVE;
                  idx_r      <= 4'd0;
                  base_r     <= base_addr;
                  busy_r     <= 1'b1;
                  mem_we_r   <= 1'b1;
                  mem_addr_r <= base_addr;
               end else if (restore_req) begin
                  state_r    <= RESTORE;
                  idx_r      <= 4'd0;
                  base_r     <= base_addr;
                  busy_r     <= 1'b1;
                  mem_re_r   <= 1'b1;
                  mem_addr_r <= base_addr;
               end else begin
                  busy_r <= 1'b0;
               end
            end
            SAVE: begin
               if (idx_r == LAST_IDX) begin
                  state_r <= DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end else begin
                  idx_r        <= idx_inc_s;
                  mem_we_r     <= 1'b1;
                  mem_addr_r   <= next_addr_s;
                  gpr_r_addr_r <= idx_inc_s;
               end
            end
            RESTORE: begin
               if (idx_r == FINAL_IDX) begin
                  state_r <= DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end else begin
                  // The read issued this cycle returns next cycle and is written then
                  idx_r          <= idx_inc_s;
                  gpr_w_enable_r <= 1'b1;
                  gpr_w_addr_r   <= idx_r;
                  if (idx_r != LAST_IDX) begin
                     mem_re_r   <= 1'b1;
                     mem_addr_r <= next_addr_s;
                  end else begin
                     mem_re_r <= 1'b0;
                  end
               end
            end
            DONE: begin
               // Requests seen during the done pulse are not accepted
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign busy         = busy_r;
   assign done         = done_r;
   assign gpr_r_addr   = gpr_r_addr_r;
   assign gpr_w_enable = gpr_w_enable_r;
   assign gpr_w_addr   = gpr_w_addr_r;
   assign gpr_w_data   = gpr_w_enable_r ? mem_rdata : {DATA_W{1'b0}};
   assign mem_addr     = mem_addr_r;
   assign mem_we       = mem_we_r;
   assign mem_wdata    = mem_we_r ? gpr_r_data : {DATA_W{1'b0}};
   assign mem_re       = mem_re_r;

endmodule

// File: tb/tb_gpr_ctx_mover.sv
// Self-checking bench for gpr_ctx_mover: a behavioural GPR file and data
// memory surround the DUT, and a transaction-level model predicts every
// cycle's outputs from the request schedule and its own copies of memory/GPRs.
module tb_gpr_ctx_mover;
   localparam int NR = 9;

   logic       clk = 1'b0;
   logic       rst;
   logic       save_req;
   logic       restore_req;
   logic [7:0] base_addr;
   logic       busy;
   logic       done;
   logic [3:0] gpr_r_addr;
   logic [7:0] gpr_r_data;
   logic       gpr_w_enable;
   logic [3:0] gpr_w_addr;
   logic [7:0] gpr_w_data;
   logic [7:0] mem_addr;
   logic       mem_we;
   logic [7:0] mem_wdata;
   logic       mem_re;
   logic [7:0] mem_rdata;

   // Bench-side environment storage and a one-cycle poke port into it
   logic [7:0] env_mem [256];
   logic [7:0] env_gpr [16];
   logic       env_clear;
   logic       poke_mem_en;
   logic       poke_gpr_en;
   logic [7:0] poke_addr;
   logic [7:0] poke_data;

   // Model state
   logic [7:0] exp_mem [256];
   logic [7:0] exp_gpr [16];
   int         m_kind;      // 0 idle, 1 save, 2 restore, 3 done pulse
   int         m_rel;       // cycle number within the transfer
   logic [7:0] m_base;
   logic [7:0] m_rd_data;   // byte returned by the read issued last cycle
   bit         m_after_rst;

   int checks   = 0;
   int failures = 0;
   bit last_done, last_busy, last_we;

   gpr_ctx_mover dut (
      .clk(clk), .rst(rst), .save_req(save_req), .restore_req(restore_req),
      .base_addr(base_addr), .busy(busy), .done(done),
      .gpr_r_addr(gpr_r_addr), .gpr_r_data(gpr_r_data),
      .gpr_w_enable(gpr_w_enable), .gpr_w_addr(gpr_w_addr), .gpr_w_data(gpr_w_data),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_re(mem_re), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   assign gpr_r_data = env_gpr[gpr_r_addr];

   // Environment: memory/GPR writes, 1-cycle memory read latency, bench pokes
   always @(posedge clk) begin
      if (env_clear) begin
         for (int i = 0; i < 256; i++) env_mem[i] <= 8'(i) ^ 8'h5C;
         for (int i = 0; i < 16; i++) env_gpr[i] <= 8'(i);
      end
      if (mem_we) env_mem[mem_addr] <= mem_wdata;
      if (gpr_w_enable) env_gpr[gpr_w_addr] <= gpr_w_data;
      mem_rdata <= mem_re ? env_mem[mem_addr] : 8'hEE;
      if (poke_mem_en) env_mem[poke_addr] <= poke_data;
      if (poke_gpr_en) env_gpr[poke_addr[3:0]] <= poke_data;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Predict and compare this cycle's outputs, then advance the model
   task automatic model_cycle();
      logic       e_busy, e_done, e_we, e_re, e_gwe;
      logic [7:0] e_maddr, e_wdata, e_gdata;
      logic [3:0] e_raddr, e_gaddr;
      e_busy = 1'b0; e_done = 1'b0; e_we = 1'b0; e_re = 1'b0; e_gwe = 1'b0;
      e_maddr = 8'h00; e_wdata = 8'h00; e_gdata = 8'h00; e_raddr = 4'h0; e_gaddr = 4'h0;
      case (m_kind)
         1: begin
            e_busy = 1'b1; e_we = 1'b1;
            e_maddr = 8'(m_base + 8'(m_rel));
            e_raddr = 4'(m_rel);
            e_wdata = exp_gpr[m_rel];
         end
         2: begin
            e_busy = 1'b1;
            if (m_rel < NR) begin
               e_re = 1'b1;
               e_maddr = 8'(m_base + 8'(m_rel));
            end
            if (m_rel >= 1) begin
               e_gwe = 1'b1;
               e_gaddr = 4'(m_rel - 1);
               e_gdata = m_rd_data;
            end
         end
         3: e_done = 1'b1;
         default: ;
      endcase
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("mem_we", mem_we, e_we);
      chk("mem_re", mem_re, e_re);
      chk("gpr_w_enable", gpr_w_enable, e_gwe);
      if (e_we) begin
         chk("save_mem_addr", mem_addr, e_maddr);
         chk("gpr_r_addr", gpr_r_addr, e_raddr);
         chk("mem_wdata", mem_wdata, e_wdata);
      end
      if (e_re) chk("restore_mem_addr", mem_addr, e_maddr);
      if (e_gwe) begin
         chk("gpr_w_addr", gpr_w_addr, e_gaddr);
         chk("gpr_w_data", gpr_w_data, e_gdata);
      end
      if (m_after_rst) begin
         chk("rst_mem_addr", mem_addr, 8'h00);
         chk("rst_gpr_r_addr", gpr_r_addr, 4'h0);
         chk("rst_gpr_w_addr", gpr_w_addr, 4'h0);
         chk("rst_gpr_w_data", gpr_w_data, 8'h00);
         chk("rst_mem_wdata", mem_wdata, 8'h00);
      end
      last_done = done; last_busy = busy; last_we = mem_we;
      // Memory answers a read one cycle later with the value seen at issue
      if (e_re) m_rd_data = exp_mem[e_maddr];
      if (e_we) exp_mem[e_maddr] = e_wdata;
      if (e_gwe) exp_gpr[e_gaddr] = e_gdata;
      if (env_clear) begin
         for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i) ^ 8'h5C;
         for (int i = 0; i < 16; i++) exp_gpr[i] = 8'(i);
      end
      if (poke_mem_en) exp_mem[poke_addr] = poke_data;
      if (poke_gpr_en) exp_gpr[poke_addr[3:0]] = poke_data;
      m_after_rst = rst;
      if (rst) m_kind = 0;
      else begin
         case (m_kind)
            0: if (save_req || restore_req) begin
                  m_kind = save_req ? 1 : 2; m_rel = 0; m_base = base_addr;
               end
            1: if (m_rel == NR - 1) m_kind = 3; else m_rel++;
            2: if (m_rel == NR) m_kind = 3; else m_rel++;
            default: m_kind = 0;
         endcase
      end
   endtask

   task automatic step();
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #2;
      save_req = 1'b0; restore_req = 1'b0;
      poke_mem_en = 1'b0; poke_gpr_en = 1'b0; env_clear = 1'b0;
   endtask

   task automatic poke_gpr(input int idx, input logic [7:0] val);
      poke_gpr_en = 1'b1; poke_addr = 8'(idx); poke_data = val;
      step();
   endtask

   task automatic poke_mem(input logic [7:0] addr, input logic [7:0] val);
      poke_mem_en = 1'b1; poke_addr = addr; poke_data = val;
      step();
   endtask

   // Issue a request; count cycles until done plus busy and mem_we cycles on the way
   task automatic run_req(input bit s, input bit r, input logic [7:0] base, input bit mid_restore,
                          output int lat, output int nbusy, output int nwe);
      save_req = s; restore_req = r; base_addr = base;
      step();
      lat = 0; nbusy = 0; nwe = 0;
      for (int k = 0; k < 30; k++) begin
         if (mid_restore && k == 4) begin restore_req = 1'b1; base_addr = 8'h80; end
         step();
         lat++;
         if (last_busy) nbusy++;
         if (last_we) nwe++;
         if (last_done) break;
      end
   endtask

   int lat, nbusy, nwe, extra;
   logic [7:0] a;

   initial begin
      rst = 1'b1; save_req = 1'b0; restore_req = 1'b0; base_addr = 8'h00;
      poke_mem_en = 1'b0; poke_gpr_en = 1'b0; poke_addr = 8'h00; poke_data = 8'h00;
      env_clear = 1'b1;
      m_kind = 0; m_rel = 0; m_base = 8'h00; m_rd_data = 8'h00; m_after_rst = 1'b1;
      step(); step(); step();
      rst = 1'b0;
      step();

      // 1: save r0..r8 = 0x11..0x99 to 0x40
      for (int i = 0; i < NR; i++) poke_gpr(i, 8'(8'h11 * (i + 1)));
      run_req(1'b1, 1'b0, 8'h40, 1'b0, lat, nbusy, nwe);
      chk("t1_latency", lat, 10);
      chk("t1_busy_cycles", nbusy, 9);
      for (int i = 0; i < NR; i++) chk("t1_mem", env_mem[8'h40 + i], 8'(8'h11 * (i + 1)));
      chk("t1_model_mem48", exp_mem[8'h48], 8'h99);

      // 2: restore from 0x80 holding 0xA0..0xA8
      for (int i = 0; i < NR; i++) poke_mem(8'(8'h80 + i), 8'(8'hA0 + i));
      run_req(1'b0, 1'b1, 8'h80, 1'b0, lat, nbusy, nwe);
      chk("t2_latency", lat, 11);
      chk("t2_no_mem_we", nwe, 0);
      for (int i = 0; i < NR; i++) chk("t2_gpr", env_gpr[i], 8'(8'hA0 + i));
      chk("t2_model_gpr8", exp_gpr[8], 8'hA8);

      // 3: save at 0xFC wraps to 0x00..0x04
      run_req(1'b1, 1'b0, 8'hFC, 1'b0, lat, nbusy, nwe);
      for (int i = 0; i < NR; i++) begin
         a = 8'hFC + 8'(i);
         chk("t3_wrap_mem", env_mem[a], 8'(8'hA0 + i));
      end
      chk("t3_mem04", env_mem[8'h04], 8'hA8);

      // 4: simultaneous requests -> SAVE only; restore mid-save ignored
      for (int i = 0; i < NR; i++) poke_gpr(i, 8'(8'h30 + i));
      run_req(1'b1, 1'b1, 8'h10, 1'b1, lat, nbusy, nwe);
      chk("t4_latency", lat, 10);
      chk("t4_we_cycles", nwe, 9);
      extra = 0;
      for (int k = 0; k < 14; k++) begin step(); if (last_done) extra++; end
      chk("t4_extra_done", extra, 0);
      chk("t4_gpr0_untouched", env_gpr[0], 8'h30);

      // 5: reset during restore after r0..r2 are written
      restore_req = 1'b1; base_addr = 8'h80;
      step();
      step(); step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      extra = 0;
      for (int k = 0; k < 12; k++) begin step(); if (last_done || last_busy) extra++; end
      chk("t5_quiet_after_rst", extra, 0);
      for (int i = 0; i < 3; i++) chk("t5_gpr_written", env_gpr[i], 8'(8'hA0 + i));
      for (int i = 3; i < NR; i++) chk("t5_gpr_kept", env_gpr[i], 8'(8'h30 + i));

      // 6: save, back-to-back restore clobbers GPRs, restore the saved frame
      for (int i = 0; i < NR; i++) poke_gpr(i, 8'(8'h3C + 7 * i));
      run_req(1'b1, 1'b0, 8'hC0, 1'b0, lat, nbusy, nwe);
      run_req(1'b0, 1'b1, 8'h80, 1'b0, lat, nbusy, nwe);
      chk("t6_b2b_latency", lat, 11);
      chk("t6_clobbered", env_gpr[4], 8'hA4);
      run_req(1'b0, 1'b1, 8'hC0, 1'b0, lat, nbusy, nwe);
      for (int i = 0; i < NR; i++) chk("t6_roundtrip", env_gpr[i], 8'(8'h3C + 7 * i));

      // Random traffic against the model
      for (int c = 0; c < 2500; c++) begin
         rst = ($urandom_range(0, 299) == 0);
         save_req = ($urandom_range(0, 9) == 0);
         restore_req = ($urandom_range(0, 9) == 0);
         base_addr = 8'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 1) == 0) begin
               poke_mem_en = 1'b1; poke_addr = 8'($urandom);
            end else begin
               poke_gpr_en = 1'b1; poke_addr = 8'($urandom_range(0, NR - 1));
            end
            poke_data = 8'($urandom);
         end
         step();
      end
      rst = 1'b0;
      for (int k = 0; k < 15; k++) step();
      for (int i = 0; i < 256; i++) chk("final_mem", env_mem[i], exp_mem[i]);
      for (int i = 0; i < NR; i++) chk("final_gpr", env_gpr[i], exp_gpr[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
